// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the board input conditioner.
// Debounce counter widths are derived here so every unit sizes its counter alike.
package input_cond_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int SIM_DEBOUNCE     = 4;

  // Counter must hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(int cycles);
    if (cycles < 1) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_unit.sv
// Synchroniser chain plus counter debouncer for a WIDTH-bit word.
// The word is accepted only after it has been stable as a whole for DEBOUNCE_CYCLES.
module debounce_unit
  import input_cond_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic             changed
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any bit differing from the candidate restarts the whole-word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand    <= '0;
      level   <= '0;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cand == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level   <= cand;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw push-buttons and the slide-switch bus for the SLC-3 datapath.
// Buttons debounce independently; the switch bus debounces as one word.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int              N_CH            = 3,
  parameter int              SW_WIDTH        = 16,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [N_CH-1:0] INVERT          = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_CH-1:0]     btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [N_CH-1:0]     btn_level,
  output logic [N_CH-1:0]     btn_rise,
  output logic [N_CH-1:0]     btn_fall,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic                sw_changed
);

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_chg;

  assign btn_in = btn_raw ^ INVERT;

  for (genvar i = 0; i < N_CH; i++) begin : g_btn
    debounce_unit #(
      .WIDTH          (1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_btn (
      .clk    (Clk),
      .rst    (Reset),
      .raw    (btn_in[i]),
      .level  (btn_level[i]),
      .changed(btn_chg[i])
    );
  end

  // Change pulse and new level come from the same edge, so the level gives direction.
  assign btn_rise = btn_chg & btn_level;
  assign btn_fall = btn_chg & ~btn_level;

  debounce_unit #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_sw (
    .clk    (Clk),
    .rst    (Reset),
    .raw    (sw_raw),
    .level  (sw_out),
    .changed(sw_changed)
  );

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: a stability-run reference model predicts every cycle's outputs,
// a monitor on the falling edge compares the DUT against the queued predictions.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int             N_CH = 3;
  localparam int             SW_W = 16;
  localparam int             SYNC = 2;
  localparam int             DEB  = SIM_DEBOUNCE;
  localparam logic [N_CH-1:0] INV = 3'b001;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N_CH-1:0] btn_raw;
  logic [SW_W-1:0] sw_raw;
  logic [N_CH-1:0] btn_level, btn_rise, btn_fall;
  logic [SW_W-1:0] sw_out;
  logic            sw_changed;

  input_conditioner #(
    .N_CH(N_CH), .SW_WIDTH(SW_W), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .INVERT(INV)
  ) dut (
    .Clk(Clk), .Reset(Reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .sw_out(sw_out), .sw_changed(sw_changed)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [SW_W-1:0] sw;
    logic            chg;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: raw values reach the debouncer SYNC edges late; a value that
  // differs from the accepted level is taken once it has been seen DEB+1 edges running.
  logic [N_CH-1:0] bpipe[$];
  logic [SW_W-1:0] spipe[$];
  logic [N_CH-1:0] m_level, b_prev;
  int              b_run [N_CH];
  logic [SW_W-1:0] m_sw, s_prev;
  int              s_run;
  logic [N_CH-1:0] bs;
  logic [SW_W-1:0] ss;
  exp_t            e;

  always @(posedge Clk) begin
    e.rise = '0; e.fall = '0; e.chg = 1'b0;
    if (Reset) begin
      bpipe.delete(); spipe.delete();
      for (int i = 0; i < SYNC; i++) begin
        bpipe.push_back('0); spipe.push_back('0);
      end
      m_level = '0; b_prev = '0; m_sw = '0; s_prev = '0; s_run = 0;
      for (int c = 0; c < N_CH; c++) b_run[c] = 0;
    end else begin
      bs = bpipe.pop_front(); bpipe.push_back(btn_raw ^ INV);
      ss = spipe.pop_front(); spipe.push_back(sw_raw);
      for (int c = 0; c < N_CH; c++) begin
        b_run[c] = (bs[c] == b_prev[c]) ? b_run[c] + 1 : 1;
        if (bs[c] != m_level[c] && b_run[c] >= DEB + 1) begin
          m_level[c] = bs[c];
          if (bs[c]) e.rise[c] = 1'b1; else e.fall[c] = 1'b1;
        end
      end
      b_prev = bs;
      s_run  = (ss == s_prev) ? s_run + 1 : 1;
      s_prev = ss;
      if (ss != m_sw && s_run >= DEB + 1) begin
        m_sw  = ss;
        e.chg = 1'b1;
      end
    end
    e.level = m_level;
    e.sw    = m_sw;
    expq.push_back(e);
  end

  exp_t x;
  always @(negedge Clk) begin
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no prediction, required one per cycle");
    end else begin
      x = expq.pop_front();
      if (btn_level !== x.level) begin
        errors++;
        $display("FAIL btn_level @%0t: got %b, required %b", $time, btn_level, x.level);
      end
      checks++;
      if (btn_rise !== x.rise) begin
        errors++;
        $display("FAIL btn_rise @%0t: got %b, required %b", $time, btn_rise, x.rise);
      end
      checks++;
      if (btn_fall !== x.fall) begin
        errors++;
        $display("FAIL btn_fall @%0t: got %b, required %b", $time, btn_fall, x.fall);
      end
      checks++;
      if (sw_out !== x.sw) begin
        errors++;
        $display("FAIL sw_out @%0t: got %h, required %h", $time, sw_out, x.sw);
      end
      checks++;
      if (sw_changed !== x.chg) begin
        errors++;
        $display("FAIL sw_changed @%0t: got %b, required %b", $time, sw_changed, x.chg);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; btn_raw = 3'b111; sw_raw = 16'hFFFF;
    cyc(3);
    Reset = 1'b0;
    cyc(12);
    // quiet baseline, then a clean press and release on channel 1
    btn_raw = 3'b000; sw_raw = 16'h0000; cyc(12);
    btn_raw[1] = 1'b1; cyc(12);
    btn_raw[1] = 1'b0; cyc(12);
    // bounce shorter than the debounce window
    btn_raw[2] = 1'b1; cyc(3); btn_raw[2] = 1'b0; cyc(2);
    btn_raw[2] = 1'b1; cyc(3); btn_raw[2] = 1'b0; cyc(12);
    // switch word settles through an intermediate value
    sw_raw = 16'h1234; cyc(2); sw_raw = 16'h1235; cyc(14);
    // reset mid-count discards the pending acceptance
    btn_raw[2] = 1'b1; cyc(3);
    Reset = 1'b1; cyc(1); Reset = 1'b0; cyc(14);
    // inverted channel plus simultaneous event on another channel
    btn_raw[0] = 1'b1; btn_raw[1] = 1'b1; cyc(12);
    btn_raw[0] = 1'b0; btn_raw[1] = 1'b0; cyc(12);
    // randomized holds of 1..8 cycles, occasional resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) btn_raw = btn_raw ^ 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) sw_raw = sw_raw ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) sw_raw = 16'($urandom);
      Reset = ($urandom_range(0, 59) == 0);
      cyc(1);
      Reset = 1'b0;
      cyc($urandom_range(0, 7));
    end
    cyc(15);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
